encoder_nbit_seq: RTL

Sequential N-bit request encoder: the reverse direction of the N-bit one-hot decoder. Collects one-hot/multi-hot request bits into a pending register and emits one binary index per accepted transfer on a valid/ready output, clearing each bit as it is issued. Sits on the return path where the decoder fans a binary select out to 2**N targets; targets raise request bits, and this block turns them back into binary indices for a single consumer.

---
 rtl/enc_pkg.sv | 25 ++
 rtl/prio_pick_nbit.sv | 31 +++
 rtl/encoder_nbit_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared types and constants for the sequential N-bit request encoder.
// Holds the issue FSM state encoding, the request-vector width helper and a
// population-count function used for the registered pending count.
package enc_pkg;

    localparam int N = 3;       // index width
    localparam int W = 1 << N;  // request vector width, 2**N

    typedef enum logic [1:0] {
        IDLE,   // nothing held: idx_valid = 0, pending = 0
        ISSUE,  // index freshly loaded and offered to the consumer
        STALL   // index held because the consumer was not ready
    } state_t;

    // Number of set bits in a request vector (0 .. W).
    function automatic logic [N:0] popcount(input logic [W-1:0] v);
        logic [N:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + {{N{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_pick_nbit.sv
// prio_pick_nbit: combinational priority picker.
// Returns the first set bit of vec found when searching upward from start,
// wrapping modulo 2**N. With start tied to 0 this is a plain lowest-index-wins
// priority encoder.
module prio_pick_nbit #(
    parameter int N = 3
) (
    input  logic [(1<<N)-1:0] vec,
    input  logic [N-1:0]      start,
    output logic              found,
    output logic [N-1:0]      index
);

    localparam int W = 1 << N;

    // Search from start, wrapping; the first hit wins and later hits are ignored.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        found = 1'b0;
        index = '0;
        for (int k = 0; k < W; k++) begin
            // N-bit addition wraps naturally, giving the modulo-2**N search order.
            if (!found && vec[start + k[N-1:0]]) begin
                found = 1'b1;
                index = start + k[N-1:0];
            end
        end
    end

endmodule

// File: rtl/encoder_nbit_seq.sv
// encoder_nbit_seq: sequential N-bit request encoder.
// Merges incoming request bits into a pending set and issues one binary index
// per accepted valid/ready transfer, clearing each bit as it is issued.
// Optional feature: define ENC_ROUND_ROBIN_EN for rotating priority (search
// starts after the last issued index); default build uses fixed priority,
// lowest index first, and has no pointer register.
module encoder_nbit_seq
    import enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] req,
    input  logic         enable,
    output logic [N-1:0] idx,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [W-1:0] pending,
    output logic [N:0]   pend_cnt
);

    state_t       state, state_nxt;
    logic [W-1:0] merged;
    logic         load;
    logic         found;
    logic [N-1:0] pick;
    logic [N-1:0] start;
    logic [W-1:0] pending_nxt;
    logic [N-1:0] idx_nxt;

    // Requests seen this cycle join whatever is still waiting.
    assign merged    = pending | (enable ? req : '0);
    // A new index may be loaded when the output slot is empty or being drained.
    assign load      = !idx_valid || idx_ready;
    assign idx_valid = (state != IDLE);

`ifdef ENC_ROUND_ROBIN_EN
    localparam logic [N-1:0] ONE = 1;
    logic [N-1:0] ptr;

    // Search begins just past the last issued index.
    assign start = ptr + ONE;

    // Remember the index issued on each load; reset points at the top so the
    // first search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '1;
        end else if (load && found) begin
            ptr <= pick;
        end
    end
`else
    assign start = '0;
`endif

    prio_pick_nbit #(.N(N)) u_pick (
        .vec   (merged),
        .start (start),
        .found (found),
        .index (pick)
    );

    // Next-state and datapath decisions: load a fresh index, go idle, or hold.
    always_comb begin
        state_nxt   = state;
        pending_nxt = merged;
        idx_nxt     = idx;
        if (load) begin
            if (found) begin
                state_nxt   = ISSUE;
                idx_nxt     = pick;
                pending_nxt = merged & ~(W'(1) << pick);
            end else begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        end else begin
            // Consumer stalled: idx holds, new requests still collect.
            state_nxt = STALL;
        end
    end

    // State, held index, pending set and its count all update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state    <= state_nxt;
            idx      <= idx_nxt;
            pending  <= pending_nxt;
            pend_cnt <= popcount(pending_nxt);
        end
    end

endmodule
